// File: rtl/neuron_sequencer.sv
// neuron_sequencer: streams N_INPUTS samples against a synchronous weight ROM, adds the bias word and
// emits a saturated fixed-point neuron output. Define NEURON_SEQ_RELU_EN to clamp negative results to zero.
module neuron_sequencer #(
  parameter int DEPTH    = 3,
  parameter int WIDTH    = 8,
  parameter int N_INPUTS = 4,
  parameter int FRAC     = 0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic signed [WIDTH-1:0] data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [DEPTH-1:0]        rom_addr_o,
  input  logic signed [WIDTH-1:0] rom_data_i,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i
);

  localparam int AW = 2*WIDTH + DEPTH;
  localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(N_INPUTS - 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {FILL, ACCUM, BIAS, OUT} state_t;

  state_t                   state, state_nxt;
  logic [DEPTH-1:0]         idx, idx_nxt;
  logic signed [AW-1:0]     acc, acc_nxt;
  logic signed [2*WIDTH-1:0] data_ext, rom_ext, prod;
  logic signed [AW-1:0]     prod_ext, bias_ext, bias_sh, bias_sum, shifted;
  logic signed [WIDTH-1:0]  data_nxt;

  assign data_ext = {{WIDTH{data_i[WIDTH-1]}}, data_i};
  assign rom_ext  = {{WIDTH{rom_data_i[WIDTH-1]}}, rom_data_i};
  assign prod     = data_ext * rom_ext;
  assign prod_ext = {{DEPTH{prod[2*WIDTH-1]}}, prod};
  assign bias_ext = {{(AW-WIDTH){rom_data_i[WIDTH-1]}}, rom_data_i};
  assign bias_sh  = bias_ext <<< FRAC;
  // Output is computed from acc+bias during BIAS so data_o is registered on the edge entering OUT.
  assign bias_sum = acc + bias_sh;
  assign shifted  = bias_sum >>> FRAC;

  always_comb begin
    data_nxt = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      data_nxt = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      data_nxt = SAT_MIN[WIDTH-1:0];
    end
`ifdef NEURON_SEQ_RELU_EN
    if (shifted[AW-1]) begin
      data_nxt = '0;
    end
`endif
  end

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    acc_nxt    = acc;
    ready_o    = 1'b0;
    rom_addr_o = '0;
    valid_o    = 1'b0;
    case (state)
      FILL: begin
        state_nxt = ACCUM;
        idx_nxt   = '0;
      end
      ACCUM: begin
        ready_o    = 1'b1;
        rom_addr_o = idx;
        if (valid_i) begin
          // Look one address ahead so the next weight lands with the next sample.
          rom_addr_o = idx + DEPTH'(1);
          acc_nxt    = acc + prod_ext;
          idx_nxt    = idx + DEPTH'(1);
          if (idx == LAST_IDX) begin
            state_nxt = BIAS;
          end
        end
      end
      BIAS: begin
        acc_nxt   = bias_sum;
        state_nxt = OUT;
      end
      OUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          acc_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state  <= FILL;
      idx    <= '0;
      acc    <= '0;
      data_o <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      acc   <= acc_nxt;
      if (state == BIAS) begin
        data_o <= data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Testbench for neuron_sequencer: two instances (FRAC=0 and FRAC=2) run in lockstep on shared stimulus,
// each with its own synchronous ROM model; results are checked through a scoreboard queue.
module tb_neuron_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i, valid_i, ready_i;
  logic signed [7:0] data_i;
  logic              ready0, valid0, ready2, valid2;
  logic [2:0]        addr0, addr2;
  logic signed [7:0] rq0, rq2, dout0, dout2;
  logic [7:0]        rom0 [8];
  logic [7:0]        rom2 [8];

  neuron_sequencer #(.DEPTH(3), .WIDTH(8), .N_INPUTS(4), .FRAC(0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready0),
    .rom_addr_o(addr0), .rom_data_i(rq0), .data_o(dout0), .valid_o(valid0), .ready_i(ready_i));

  neuron_sequencer #(.DEPTH(3), .WIDTH(8), .N_INPUTS(4), .FRAC(2)) dut2 (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i), .ready_o(ready2),
    .rom_addr_o(addr2), .rom_data_i(rq2), .data_o(dout2), .valid_o(valid2), .ready_i(ready_i));

  always @(posedge clk) begin
    rq0 <= rom0[addr0];
    rq2 <= rom2[addr2];
  end

`ifdef NEURON_SEQ_RELU_EN
  localparam int E_N128 = 0, E_N23 = 0, E_N9 = 0, E_N50 = 0;
`else
  localparam int E_N128 = -128, E_N23 = -23, E_N9 = -9, E_N50 = -50;
`endif

  typedef struct packed {
    logic [3:0][7:0]   w;
    logic [7:0]        b;
    logic [3:0][7:0]   x;
    logic              gap;
    logic              hold;
    logic signed [7:0] e0;
    logic signed [7:0] e2;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   q0[$];
  int   q2[$];
  logic pv0 = 1'b0;
  logic pv2 = 1'b0;
  vec_t tbl [10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input int w0, w1, w2, w3, b, x0, x1, x2, x3, gap, hold, e0, e2);
    vec_t v;
    v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
    v.b    = 8'(b);
    v.x[0] = 8'(x0); v.x[1] = 8'(x1); v.x[2] = 8'(x2); v.x[3] = 8'(x3);
    v.gap  = 1'(gap);
    v.hold = 1'(hold);
    v.e0   = 8'(e0);
    v.e2   = 8'(e2);
    return v;
  endfunction

  // Each output is scored once, on the cycle valid_o rises.
  always @(negedge clk) begin
    if (valid0 && !pv0) begin
      if (q0.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_out0: got %0d expected no output", dout0);
      end else check("out_frac0", dout0, q0.pop_front());
    end
    if (valid2 && !pv2) begin
      if (q2.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_out2: got %0d expected no output", dout2);
      end else check("out_frac2", dout2, q2.pop_front());
    end
    pv0 <= valid0;
    pv2 <= valid2;
  end

  task automatic load_rom(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      rom0[i] = v.w[i];
      rom2[i] = v.w[i];
    end
    rom0[4] = v.b;
    rom2[4] = v.b;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_one(input logic [7:0] x, input int k);
    int n;
    data_i  = x;
    valid_i = 1'b1;
    #1;
    n = 0;
    while (!ready0 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!ready0) begin
      n_checks++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 50 cycles");
    end
    check("addr_accept", addr0, k + 1);
    check("addr_lockstep", addr2, addr0);
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic run(input vec_t v);
    int n;
    load_rom(v);
    ready_i = !v.hold;
    q0.push_back(v.e0);
    q2.push_back(v.e2);
    for (int k = 0; k < 4; k++) begin
      drive_one(v.x[k], k);
      if (v.gap && k < 3) begin
        #1;
        check("addr_hold", addr0, k + 1);
        @(negedge clk);
      end
    end
    #1;
    check("lat_bias_valid", valid0, 0);
    @(negedge clk);
    #1;
    check("lat_out_valid", valid0, 1);
    if (v.hold) begin
      for (int c = 0; c < 5; c++) begin
        valid_i = 1'b1;
        data_i  = 8'sd99;
        @(negedge clk);
        #1;
        check("hold_valid", valid0, 1);
        check("hold_data", dout0, v.e0);
        check("hold_ready", ready0, 0);
        check("hold_addr", addr0, 0);
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q2.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q0.size() + q2.size());
      q0.delete();
      q2.delete();
    end
  endtask

  initial begin
    reset_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    for (int i = 0; i < 8; i++) begin
      rom0[i] = '0;
      rom2[i] = '0;
    end
    tbl[0] = mk(1, 2, 3, 4, 5,       1, 1, 1, 1,      0, 0, 15, 7);
    tbl[1] = mk(1, 2, 3, 4, 5,       1, 1, 1, 1,      1, 0, 15, 7);
    tbl[2] = mk(127, 127, 127, 127, 0, 127, 127, 127, 127, 0, 0, 127, 127);
    tbl[3] = mk(127, 127, 127, 127, 0, -128, -128, -128, -128, 0, 0, E_N128, E_N128);
    tbl[4] = mk(1, 2, 3, 4, 5,       1, 1, 1, 1,      0, 1, 15, 7);
    tbl[5] = mk(1, 2, 3, 4, 5,       1, 1, 1, 1,      0, 0, 15, 7);
    tbl[6] = mk(4, 4, 4, 4, 1,       1, 1, 1, 1,      0, 0, 17, 5);
    tbl[7] = mk(3, -2, 5, -1, -4,    10, 7, -3, 20,   1, 0, E_N23, E_N9);
    tbl[8] = mk(10, 20, 30, 40, -100, 2, 2, 2, 2,     0, 0, 100, E_N50);
    tbl[9] = mk(64, 64, 0, 0, 0,     1, 1, 1, 1,      0, 0, 127, 32);

    repeat (3) @(negedge clk);
    #1;
    check("rst_data", dout0, 0);
    check("rst_valid", valid0, 0);
    check("rst_ready", ready0, 0);
    check("rst_addr", addr0, 0);
    reset_i = 1'b1;
    #1;
    check("fill_ready", ready0, 0);
    check("fill_addr", addr0, 0);
    @(negedge clk);
    #1;
    check("accum_ready", ready0, 1);

    for (int t = 0; t < 10; t++) run(tbl[t]);

    // Reset partway through a pass: outputs drop at once and the partial sum is discarded.
    load_rom(tbl[0]);
    drive_one(8'sd1, 0);
    drive_one(8'sd1, 1);
    #2;
    reset_i = 1'b0;
    #1;
    check("midrst_data", dout0, 0);
    check("midrst_valid", valid0, 0);
    check("midrst_ready", ready0, 0);
    check("midrst_addr", addr0, 0);
    check("midrst_data2", dout2, 0);
    @(negedge clk);
    reset_i = 1'b1;
    run(tbl[0]);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
